// File: rtl/aes_round_key_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_key_bank_if
// Description : Bundle for the round-key broadcast (key word, one-hot write
//               strobe, schedule restart) and the indexed key read port.
//               The master is the key controller or debug agent. The slave
//               is the round-key bank.
// Ports (master view)
//   key_in      out  KEY_W   round-key word being broadcast
//   set_key     out  NUM_RK  one-hot write strobe, bit i targets rk[i]
//   sched_start out  1       a new key schedule begins
//   rd_req      out  1       read request, single-cycle qualifier
//   rd_idx      out  IDX_W   requested round index
//   rd_inv      out  1       read in inverse round order
//   rd_ack      in   1       read response valid
//   rd_key      in   KEY_W   read data, qualified by rd_ack
//   rd_err      in   1       read rejected
// Revision    : 1.0  initial release
// ============================================================================
interface aes_round_key_bank_if #(
  parameter int KEY_W  = 128,
  parameter int NUM_RK = 11,
  parameter int IDX_W  = 4
);
  logic [KEY_W-1:0]  key_in;
  logic [NUM_RK-1:0] set_key;
  logic              sched_start;
  logic              rd_req;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_inv;
  logic              rd_ack;
  logic [KEY_W-1:0]  rd_key;
  logic              rd_err;

  modport master (
    output key_in, set_key, sched_start, rd_req, rd_idx, rd_inv,
    input  rd_ack, rd_key, rd_err
  );

  modport slave (
    input  key_in, set_key, sched_start, rd_req, rd_idx, rd_inv,
    output rd_ack, rd_key, rd_err
  );
endinterface
`default_nettype wire

// File: rtl/aes_round_key_bank.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_key_bank
// Description : Receive end of the round-key broadcast. Stores the AES-128
//               round keys and tracks which keys the current schedule has
//               loaded. All keys are presented in parallel to the round
//               pipeline. A registered indexed read port, in forward or
//               inverse order, serves the decrypt path and debug.
// Ports
//   clk         in   1             clock, all logic on the rising edge
//   rst_n       in   1             synchronous active-low reset
//   bus         slave              key broadcast and read port
//   err_clr     in   1             clears err_multi
//   rk_flat     out  NUM_RK*KEY_W  all stored keys, rk[i] at [i*KEY_W +: KEY_W]
//   valid_map   out  NUM_RK        bit i = rk[i] loaded in this schedule
//   keys_ready  out  1             all keys loaded (READY state)
//   err_multi   out  1             sticky, a multi-hot set_key was seen
// Revision    : 1.0  initial release
// ============================================================================
module aes_round_key_bank #(
  parameter int KEY_W  = 128,
  parameter int NUM_RK = 11,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  aes_round_key_bank_if.slave      bus,
  input  logic                     err_clr,
  output logic [NUM_RK*KEY_W-1:0]  rk_flat,
  output logic [NUM_RK-1:0]        valid_map,
  output logic                     keys_ready,
  output logic                     err_multi
);

  localparam logic [NUM_RK-1:0] c_SET_ONE  = NUM_RK'(1);
  localparam logic [NUM_RK-1:0] c_ALL_ONES = '1;
  localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(NUM_RK - 1);
  localparam logic [IDX_W:0]    c_NUM_RK_X = (IDX_W + 1)'(NUM_RK);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [KEY_W-1:0]  r_rk [NUM_RK];
  logic [NUM_RK-1:0] r_valid;
  logic [NUM_RK-1:0] w_valid_nxt;
  logic              r_err_multi;

  logic              w_set_any;
  logic              w_set_multi;
  logic              w_wr_legal;

  logic [IDX_W-1:0]  w_eff_idx;
  logic              w_rd_in_range;
  logic              w_rd_good;
  logic [KEY_W-1:0]  w_rd_data;

  logic              r_rd_ack;
  logic              r_rd_err;
  logic [KEY_W-1:0]  r_rd_key;

  // --------------------------------------------------------------------------
  // Write strobe classification. Clearing the lowest set bit leaves a
  // non-zero value only when two or more strobe bits are set.
  // --------------------------------------------------------------------------
  assign w_set_any   = |bus.set_key;
  assign w_set_multi = |(bus.set_key & (bus.set_key - c_SET_ONE));
  assign w_wr_legal  = w_set_any & ~w_set_multi;

  // --------------------------------------------------------------------------
  // Key storage. Only a legal one-hot strobe writes, so at most one register
  // changes per cycle. Values survive sched_start; only validity is cleared.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RK; i++) begin
        r_rk[i] <= '0;
      end
    end else if (w_wr_legal) begin
      for (int i = 0; i < NUM_RK; i++) begin
        if (bus.set_key[i]) begin
          r_rk[i] <= bus.key_in;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Validity tracking. sched_start clears the map first so that a write in
  // the same cycle still marks its own key as loaded in the new schedule.
  // --------------------------------------------------------------------------
  always_comb begin
    w_valid_nxt = bus.sched_start ? '0 : r_valid;
    if (w_wr_legal) begin
      w_valid_nxt = w_valid_nxt | bus.set_key;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Load-progress FSM. READY is judged on the next map so that keys_ready
  // rises the cycle after the edge that captures the last missing key.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (bus.sched_start || w_wr_legal) begin
          w_state_nxt = (w_valid_nxt == c_ALL_ONES) ? ST_READY : ST_LOADING;
        end
      end
      ST_LOADING: begin
        if (w_valid_nxt == c_ALL_ONES) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        // A plain overwrite keeps the schedule complete and stays here.
        if (bus.sched_start) begin
          w_state_nxt = ST_LOADING;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Multi-hot error flag. A new error wins over a clear in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_multi <= 1'b0;
    end else if (w_set_multi) begin
      r_err_multi <= 1'b1;
    end else if (err_clr) begin
      r_err_multi <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Read port. The range check uses the raw index; an out-of-range index
  // may wrap in the inverse subtraction but is rejected before use.
  // --------------------------------------------------------------------------
  assign w_eff_idx     = bus.rd_inv ? (c_LAST_IDX - bus.rd_idx) : bus.rd_idx;
  assign w_rd_in_range = ({1'b0, bus.rd_idx} < c_NUM_RK_X);
  assign w_rd_good     = (r_state == ST_READY) && w_rd_in_range;

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (w_eff_idx == IDX_W'(i)) begin
        w_rd_data = r_rk[i];
      end
    end
  end

  // Reads sample the key registers before this edge's write, so a read and a
  // write to the same index in one cycle return the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
      r_rd_key <= '0;
    end else begin
      r_rd_ack <= bus.rd_req;
      r_rd_err <= bus.rd_req && !w_rd_good;
      r_rd_key <= (bus.rd_req && w_rd_good) ? w_rd_data : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_RK; g++) begin : g_flat
    assign rk_flat[g*KEY_W +: KEY_W] = r_rk[g];
  end

  assign valid_map   = r_valid;
  assign keys_ready  = (r_state == ST_READY);
  assign err_multi   = r_err_multi;
  assign bus.rd_ack  = r_rd_ack;
  assign bus.rd_err  = r_rd_err;
  assign bus.rd_key  = r_rd_key;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_key_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_key_bank
// Description : Directed bench for aes_round_key_bank. A behavioural model
//               of the key bank is compared with the DUT every cycle, and
//               directed steps check hand-computed FIPS-197 values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aes_round_key_bank;

  typedef logic [1407:0] wide_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        err_clr;
  wide_t       rk_flat;
  logic [10:0] valid_map;
  logic        keys_ready;
  logic        err_multi;

  int total = 0;
  int bad   = 0;

  aes_round_key_bank_if #(.KEY_W(128), .NUM_RK(11), .IDX_W(4)) bus ();

  aes_round_key_bank #(.KEY_W(128), .NUM_RK(11), .IDX_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err_clr    (err_clr),
    .rk_flat    (rk_flat),
    .valid_map  (valid_map),
    .keys_ready (keys_ready),
    .err_multi  (err_multi)
  );

  always #5 clk = ~clk;

  logic [127:0] fips [11];

  task automatic chk(input string name, input wide_t act, input wide_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: a keyed array, a loaded-set, and the rule that the
  // bank is ready exactly when every key of the schedule is loaded.
  // --------------------------------------------------------------------------
  logic [127:0] m_rk [11];
  logic [10:0]  m_valid;
  logic         m_err;
  logic         m_ack;
  logic         m_rerr;
  logic [127:0] m_rkey;
  bit           m_live = 1'b0;

  always @(posedge clk) begin : model
    int n;
    int wi;
    int eff;
    bit good;
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) m_rk[i] = '0;
      m_valid = '0;
      m_err   = 1'b0;
      m_ack   = 1'b0;
      m_rerr  = 1'b0;
      m_rkey  = '0;
    end else begin
      good   = (m_valid == 11'h7ff) && (bus.rd_idx < 11);
      eff    = bus.rd_inv ? 10 - int'(bus.rd_idx) : int'(bus.rd_idx);
      m_ack  = bus.rd_req;
      m_rerr = bus.rd_req && !good;
      m_rkey = (bus.rd_req && good) ? m_rk[eff] : '0;
      n  = $countones(bus.set_key);
      wi = 0;
      for (int i = 0; i < 11; i++) if (bus.set_key[i]) wi = i;
      if (n > 1) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (bus.sched_start) m_valid = '0;
      if (n == 1) begin
        m_rk[wi]    = bus.key_in;
        m_valid[wi] = 1'b1;
      end
    end
    m_live = 1'b1;
  end

  always @(negedge clk) begin : compare
    wide_t m_flat;
    if (m_live) begin
      for (int i = 0; i < 11; i++) m_flat[i*128 +: 128] = m_rk[i];
      chk("m_rk_flat",    rk_flat, m_flat);
      chk("m_valid_map",  wide_t'(valid_map), wide_t'(m_valid));
      chk("m_keys_ready", wide_t'(keys_ready), wide_t'(m_valid == 11'h7ff));
      chk("m_err_multi",  wide_t'(err_multi), wide_t'(m_err));
      chk("m_rd_ack",     wide_t'(bus.rd_ack), wide_t'(m_ack));
      chk("m_rd_err",     wide_t'(bus.rd_err), wide_t'(m_rerr));
      if (m_ack) chk("m_rd_key", wide_t'(bus.rd_key), wide_t'(m_rkey));
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.key_in      = '0;
    bus.set_key     = '0;
    bus.sched_start = 1'b0;
    bus.rd_req      = 1'b0;
    bus.rd_idx      = '0;
    bus.rd_inv      = 1'b0;
    err_clr         = 1'b0;
  endtask

  task automatic load_key(input int i, input logic [127:0] k);
    bus.key_in  = k;
    bus.set_key = 11'(1 << i);
    step();
    bus.set_key = '0;
  endtask

  initial begin
    wide_t fflat;
    fips[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    fips[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    fips[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    fips[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    fips[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    fips[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    fips[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    fips[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    fips[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    fips[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    fips[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    for (int i = 0; i < 11; i++) fflat[i*128 +: 128] = fips[i];

    // 1. Reset with junk on every input
    rst_n           = 1'b0;
    bus.key_in      = {4{32'hdeadbeef}};
    bus.set_key     = 11'h7ff;
    bus.sched_start = 1'b1;
    bus.rd_req      = 1'b1;
    bus.rd_idx      = 4'hf;
    bus.rd_inv      = 1'b1;
    err_clr         = 1'b1;
    step();
    step();
    chk("rst_rk_flat",    rk_flat, '0);
    chk("rst_valid_map",  wide_t'(valid_map), '0);
    chk("rst_keys_ready", wide_t'(keys_ready), '0);
    chk("rst_err_multi",  wide_t'(err_multi), '0);
    chk("rst_rd_ack",     wide_t'(bus.rd_ack), '0);
    chk("rst_rd_err",     wide_t'(bus.rd_err), '0);
    chk("rst_rd_key",     wide_t'(bus.rd_key), '0);
    rst_n = 1'b1;
    idle();
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    chk("empty_rd_ack", wide_t'(bus.rd_ack), wide_t'(1));
    chk("empty_rd_err", wide_t'(bus.rd_err), wide_t'(1));

    // 2. FIPS-197 schedule on back-to-back strobes
    for (int i = 0; i < 11; i++) begin
      bus.key_in  = fips[i];
      bus.set_key = 11'(1 << i);
      step();
      chk($sformatf("ready_after_rk%0d", i), wide_t'(keys_ready), wide_t'(i == 10));
    end
    bus.set_key = '0;
    chk("model_rk10_pin", wide_t'(m_rk[10]), wide_t'(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));
    bus.rd_req = 1'b1;
    bus.rd_idx = 4'd10;
    step();
    chk("rd10_ack", wide_t'(bus.rd_ack), wide_t'(1));
    chk("rd10_key", wide_t'(bus.rd_key), wide_t'(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));

    // 3. Inverse-order reads on consecutive cycles
    bus.rd_inv = 1'b1;
    bus.rd_idx = 4'd0;
    step();
    chk("inv0_ack", wide_t'(bus.rd_ack), wide_t'(1));
    chk("inv0_key", wide_t'(bus.rd_key), wide_t'(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));
    bus.rd_idx = 4'd10;
    step();
    chk("inv10_ack", wide_t'(bus.rd_ack), wide_t'(1));
    chk("inv10_key", wide_t'(bus.rd_key), wide_t'(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c));
    idle();
    step();
    chk("noreq_ack", wide_t'(bus.rd_ack), wide_t'(0));
    chk("noreq_err", wide_t'(bus.rd_err), wide_t'(0));

    // 4. Restart the schedule, partial load, restart, full reload
    bus.sched_start = 1'b1;
    step();
    bus.sched_start = 1'b0;
    chk("restart_valid", wide_t'(valid_map), '0);
    chk("restart_ready", wide_t'(keys_ready), '0);
    chk("restart_keep",  rk_flat, fflat);
    for (int i = 0; i < 5; i++) load_key(i, ~fips[i]);
    chk("part5_valid", wide_t'(valid_map), wide_t'(11'h01f));
    bus.sched_start = 1'b1;
    step();
    bus.sched_start = 1'b0;
    chk("part5_restart_valid", wide_t'(valid_map), '0);
    bus.rd_req = 1'b1;
    bus.rd_idx = 4'd2;
    step();
    bus.rd_req = 1'b0;
    chk("loading_rd_err", wide_t'(bus.rd_err), wide_t'(1));
    bus.sched_start = 1'b1;
    bus.key_in      = fips[2];
    bus.set_key     = 11'h004;
    step();
    idle();
    chk("start_write_valid", wide_t'(valid_map), wide_t'(11'h004));
    for (int i = 0; i < 11; i++) if (i != 2) load_key(i, fips[i]);
    chk("reload_ready", wide_t'(keys_ready), wide_t'(1));
    chk("reload_flat",  rk_flat, fflat);

    // 5. Multi-hot strobe and error clear
    bus.key_in  = {4{32'h55aa55aa}};
    bus.set_key = 11'h003;
    step();
    chk("multi_err",  wide_t'(err_multi), wide_t'(1));
    chk("multi_flat", rk_flat, fflat);
    bus.set_key = 11'h005;
    err_clr     = 1'b1;
    step();
    chk("clr_vs_multi", wide_t'(err_multi), wide_t'(1));
    bus.set_key = '0;
    step();
    err_clr = 1'b0;
    chk("clr_err", wide_t'(err_multi), wide_t'(0));

    // 6. Out-of-range reads, same-cycle read/write of rk3
    bus.rd_req = 1'b1;
    bus.rd_idx = 4'd11;
    step();
    chk("oob11_err", wide_t'(bus.rd_err), wide_t'(1));
    chk("oob11_key", wide_t'(bus.rd_key), '0);
    bus.rd_idx = 4'd15;
    bus.rd_inv = 1'b1;
    step();
    chk("oob15inv_err", wide_t'(bus.rd_err), wide_t'(1));
    bus.rd_inv  = 1'b0;
    bus.rd_idx  = 4'd3;
    bus.key_in  = 128'h01234567_89abcdef_fedcba98_76543210;
    bus.set_key = 11'h008;
    step();
    bus.set_key = '0;
    chk("rw_same_old", wide_t'(bus.rd_key), wide_t'(128'h3d80477d_4716fe3e_1e237e44_6d7a883b));
    step();
    chk("rw_same_new", wide_t'(bus.rd_key), wide_t'(128'h01234567_89abcdef_fedcba98_76543210));
    chk("overwrite_ready", wide_t'(keys_ready), wide_t'(1));

    // Reset in the middle of a load discards everything
    idle();
    bus.sched_start = 1'b1;
    step();
    bus.sched_start = 1'b0;
    load_key(0, fips[0]);
    load_key(1, fips[1]);
    rst_n = 1'b0;
    step();
    chk("midrst_valid", wide_t'(valid_map), '0);
    chk("midrst_flat",  rk_flat, '0);
    rst_n = 1'b1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
